// File: rtl/game_pkg.sv
// Shared definitions for the memory game controller slice.
//   state_t   : controller state codes, also driven out on the phase port
//   ROUND_W   : width of the round counter
//   SEQ_W     : width of the game sequence word held by the phase blocks
//   MAX_ROUND : last round the counter can hold; a pass here ends the game
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISPLAY = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_WIN     = 3'd4,
        ST_LOSE    = 3'd5
    } state_t;

    localparam int ROUND_W = 4;
    localparam int SEQ_W   = 32;

    localparam logic [ROUND_W-1:0] MAX_ROUND = 4'd15;

endpackage

// File: rtl/game_controller_phase_launcher.sv
// Turns a one-cycle launch strobe into the phase block's reset/enable
// pulse pair and flags when the phase's completion input may be watched.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   launch    : high in the cycle the controller decides to enter the phase
//   rst_pulse : registered, high in the first cycle of the phase
//   en_pulse  : registered, high in the second cycle of the phase
//   armed     : high from the third cycle of the phase on
module phase_launcher (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    output logic rst_pulse,
    output logic en_pulse,
    output logic armed
);

    logic rst_pulse_q, rst_pulse_d;
    logic en_pulse_q,  en_pulse_d;
    logic armed_q,     armed_d;

    always_comb begin
        rst_pulse_d = launch;
        en_pulse_d  = rst_pulse_q & ~launch;
        // armed stays set after the phase is left; the controller only
        // looks at it while in the matching state, and the next launch clears it.
        armed_d     = launch ? 1'b0 : (armed_q | en_pulse_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pulse_q <= 1'b0;
            en_pulse_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            rst_pulse_q <= rst_pulse_d;
            en_pulse_q  <= en_pulse_d;
            armed_q     <= armed_d;
        end
    end

    assign rst_pulse = rst_pulse_q;
    assign en_pulse  = en_pulse_q;
    assign armed     = armed_q;

endmodule

// File: rtl/game_controller.sv
// Memory game round sequencer. Walks the display, wait and check blocks
// through each round, owns the round counter and declares win or lose.
//   clk, rst                     : system clock, async active-high reset
//   start                        : start/restart request (IDLE, WIN, LOSE)
//   rst_*/en_*                   : per-phase one-cycle reset and enable pulses
//   complete_display/wait/check  : phase completion inputs
//   game_complete                : check passed on the final round
//   round_ctr_out                : next round value from the check block
//   round_ctr                    : current round
//   phase                        : current state code
//   win, lose                    : high while in WIN / LOSE
//
// state   | meaning
// IDLE    | waiting for start after reset
// DISPLAY | display block shows the sequence for round_ctr
// WAIT    | player enters the sequence; bounded by WAIT_TIMEOUT
// CHECK   | check block result sampled CHECK_LAT cycles after en_check
// WIN     | game won, hold win until start
// LOSE    | game lost, hold lose until start
import game_pkg::*;

module game_controller #(
    parameter int WAIT_TIMEOUT = 1023,
    parameter int CHECK_LAT    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               rst_display,
    output logic               en_display,
    input  logic               complete_display,
    output logic               rst_wait,
    output logic               en_wait,
    input  logic               complete_wait,
    output logic               rst_check,
    output logic               en_check,
    input  logic               complete_check,
    input  logic               game_complete,
    input  logic [ROUND_W-1:0] round_ctr_out,
    output logic [ROUND_W-1:0] round_ctr,
    output logic [2:0]         phase,
    output logic               win,
    output logic               lose
);

    localparam int WAIT_W = 10;
    localparam int CHK_W  = 2;

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CHK_W-1:0]   chk_cnt_q, chk_cnt_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;

    logic launch_display, launch_wait, launch_check;
    logic armed_display, armed_wait, armed_check;
    logic wait_timeout, check_sample;

    phase_launcher u_launch_display (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch_display),
        .rst_pulse (rst_display),
        .en_pulse  (en_display),
        .armed     (armed_display)
    );

    phase_launcher u_launch_wait (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch_wait),
        .rst_pulse (rst_wait),
        .en_pulse  (en_wait),
        .armed     (armed_wait)
    );

    phase_launcher u_launch_check (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch_check),
        .rst_pulse (rst_check),
        .en_pulse  (en_check),
        .armed     (armed_check)
    );

    // A phase is launched on the edge that enters it; no state re-enters itself.
    assign launch_display = (state_d == ST_DISPLAY) && (state_q != ST_DISPLAY);
    assign launch_wait    = (state_d == ST_WAIT)    && (state_q != ST_WAIT);
    assign launch_check   = (state_d == ST_CHECK)   && (state_q != ST_CHECK);

    // Timers load during the rst_* cycle so the en_* cycle holds the first count.
    // WAIT: en_wait cycle holds WAIT_TIMEOUT-1, reaching 0 in the cycle that
    // decides the timeout, so LOSE is entered WAIT_TIMEOUT cycles after en_wait.
    // CHECK: en_check cycle holds CHECK_LAT, reaching 0 at the sample point.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (rst_wait) begin
            wait_cnt_d = WAIT_W'(WAIT_TIMEOUT - 1);
        end else if ((state_q == ST_WAIT) && (wait_cnt_q != '0)) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end

        chk_cnt_d = chk_cnt_q;
        if (rst_check) begin
            chk_cnt_d = CHK_W'(CHECK_LAT);
        end else if ((state_q == ST_CHECK) && (chk_cnt_q != '0)) begin
            chk_cnt_d = chk_cnt_q - 1'b1;
        end
    end

    assign wait_timeout = (state_q == ST_WAIT) && (en_wait || armed_wait) &&
                          (wait_cnt_q == '0);
    assign check_sample = (state_q == ST_CHECK) && armed_check && (chk_cnt_q == '0);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_DISPLAY;
                    round_d = '0;
                end
            end
            ST_DISPLAY: begin
                if (armed_display && complete_display) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (armed_wait && complete_wait) begin
                    state_d = ST_CHECK;
                end else if (wait_timeout) begin
                    state_d = ST_LOSE;
                end
            end
            ST_CHECK: begin
                if (check_sample) begin
                    if (!complete_check) begin
                        state_d = ST_LOSE;
                    end else if (game_complete || (round_q == MAX_ROUND)) begin
                        // A pass on the last round ends the game rather than wrapping.
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_DISPLAY;
                        round_d = round_ctr_out;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            round_q    <= '0;
            wait_cnt_q <= '0;
            chk_cnt_q  <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            wait_cnt_q <= wait_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign round_ctr = round_q;
    assign phase     = state_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

    localparam int T = 20;
    localparam int L = 2;

    localparam int S_IDLE  = 0;
    localparam int S_DISP  = 1;
    localparam int S_WAIT  = 2;
    localparam int S_CHECK = 3;
    localparam int S_WIN   = 4;
    localparam int S_LOSE  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rst_display, en_display, complete_display;
    logic       rst_wait, en_wait, complete_wait;
    logic       rst_check, en_check, complete_check, game_complete;
    logic [3:0] round_ctr_out, round_ctr;
    logic [2:0] phase;
    logic       win, lose;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: current state, cycles spent in it, round number
    int m_st, m_k, m_round;

    game_controller #(.WAIT_TIMEOUT(T), .CHECK_LAT(L)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .rst_display      (rst_display),
        .en_display       (en_display),
        .complete_display (complete_display),
        .rst_wait         (rst_wait),
        .en_wait          (en_wait),
        .complete_wait    (complete_wait),
        .rst_check        (rst_check),
        .en_check         (en_check),
        .complete_check   (complete_check),
        .game_complete    (game_complete),
        .round_ctr_out    (round_ctr_out),
        .round_ctr        (round_ctr),
        .phase            (phase),
        .win              (win),
        .lose             (lose)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] exp_vec();
        logic [2:0] ph;
        logic [3:0] rd;
        ph = 3'(m_st);
        rd = 4'(m_round);
        return {(m_st == S_DISP)  && (m_k == 0), (m_st == S_DISP)  && (m_k == 1),
                (m_st == S_WAIT)  && (m_k == 0), (m_st == S_WAIT)  && (m_k == 1),
                (m_st == S_CHECK) && (m_k == 0), (m_st == S_CHECK) && (m_k == 1),
                (m_st == S_WIN), (m_st == S_LOSE), ph, rd};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {rst_display, en_display, rst_wait, en_wait, rst_check, en_check,
                win, lose, phase, round_ctr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE;
        m_k = 0;
        m_round = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int ns, nr;
        ns = m_st;
        nr = m_round;
        case (m_st)
            S_IDLE, S_WIN, S_LOSE: if (start) begin ns = S_DISP; nr = 0; end
            S_DISP: if (m_k >= 2 && complete_display) ns = S_WAIT;
            S_WAIT: begin
                if (m_k >= 2 && complete_wait) ns = S_CHECK;
                else if (m_k == T) ns = S_LOSE;
            end
            S_CHECK: begin
                if (m_k == 1 + L) begin
                    if (!complete_check) ns = S_LOSE;
                    else if (game_complete || m_round == 15) ns = S_WIN;
                    else begin ns = S_DISP; nr = int'(round_ctr_out); end
                end
            end
            default: ns = S_IDLE;
        endcase
        m_k = (ns != m_st) ? 0 : m_k + 1;
        m_st = ns;
        m_round = nr;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        complete_display = 1'b0;
        complete_wait = 1'b0;
        complete_check = 1'b0;
        game_complete = 1'b0;
        round_ctr_out = 4'd0;
    endtask

    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (m_k < target && n < 4 * T + 20) begin
            tick();
            n++;
        end
        if (m_k < target) begin
            n_tests++;
            n_fail++;
            $error("FAIL wait_k observed=%0d expected=%0d", m_k, target);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One full round from DISPLAY entry: display, player input, check result.
    task automatic do_round(input bit pass, input bit gc, input logic [3:0] rco,
                            input int ddelay, input int wdelay);
        wait_k(2 + ddelay);
        complete_display = 1'b1;
        tick();
        complete_display = 1'b0;
        wait_k(2 + wdelay);
        complete_wait = 1'b1;
        tick();
        complete_wait = 1'b0;
        wait_k(1 + L);
        complete_check = pass;
        game_complete = gc;
        round_ctr_out = rco;
        tick();
        clear_inputs();
    endtask

    initial begin
        int e_cyc, l_cyc, cyc;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs_vec()), 32'(exp_vec()));
        chk("reset_all_zero", 32'(obs_vec()), 32'd0);
        rst = 1'b0;
        tick();

        // pass from round 0 to round 1
        do_start();
        chk("first_rst_display", 32'(rst_display), 32'd1);
        do_round(1'b1, 1'b0, 4'd1, 2, 8);
        chk("pass_phase", 32'(phase), 32'd1);
        chk("pass_round", 32'(round_ctr), 32'd1);

        // fail in round 1 keeps the counter
        do_round(1'b0, 1'b0, 4'd7, 0, 3);
        chk("fail_lose", 32'(lose), 32'd1);
        chk("fail_round", 32'(round_ctr), 32'd1);
        tick();
        do_start();
        chk("restart_lose", 32'(lose), 32'd0);
        chk("restart_round", 32'(round_ctr), 32'd0);
        do_round(1'b0, 1'b0, 4'd1, 1, 1);
        chk("fail_r0_round", 32'(round_ctr), 32'd0);

        // climb to round 15 then finish with game_complete
        do_start();
        for (int r = 1; r <= 15; r++) do_round(1'b1, 1'b0, 4'(r), r % 3, r % 5);
        chk("r15_round", 32'(round_ctr), 32'd15);
        do_round(1'b1, 1'b1, 4'd3, 0, 0);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_round", 32'(round_ctr), 32'd15);

        // round 15 pass without game_complete must still win
        do_start();
        chk("restart_win", 32'(win), 32'd0);
        for (int r = 1; r <= 15; r++) do_round(1'b1, 1'b0, 4'(r), 0, 0);
        do_round(1'b1, 1'b0, 4'd0, 0, 0);
        chk("r15_guard_win", 32'(win), 32'd1);
        chk("r15_guard_round", 32'(round_ctr), 32'd15);

        // WAIT timeout distance from en_wait to lose
        do_start();
        wait_k(2);
        complete_display = 1'b1;
        tick();
        complete_display = 1'b0;
        e_cyc = -1;
        l_cyc = -1;
        cyc = 0;
        while (l_cyc < 0 && cyc < 4 * T) begin
            if (en_wait && e_cyc < 0) e_cyc = cyc;
            if (lose) l_cyc = cyc;
            if (l_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        chk("timeout_seen", 32'(l_cyc >= 0), 32'd1);
        chk("timeout_dist", 32'(l_cyc - e_cyc), 32'(T));

        // completion in the timeout cycle wins over the timeout
        do_start();
        wait_k(2);
        complete_display = 1'b1;
        tick();
        complete_display = 1'b0;
        wait_k(T);
        complete_wait = 1'b1;
        tick();
        complete_wait = 1'b0;
        chk("late_wait_check", 32'(phase), 32'd3);
        wait_k(1 + L);
        complete_check = 1'b1;
        round_ctr_out = 4'd1;
        tick();
        clear_inputs();

        // early complete_check is ignored; deasserted at the sample point -> LOSE
        wait_k(2);
        complete_display = 1'b1;
        tick();
        complete_display = 1'b0;
        wait_k(2);
        complete_wait = 1'b1;
        tick();
        complete_wait = 1'b0;
        wait_k(L);
        complete_check = 1'b1;
        game_complete = 1'b1;
        tick();
        complete_check = 1'b0;
        game_complete = 1'b0;
        tick();
        chk("early_check_lose", 32'(lose), 32'd1);
        chk("early_check_round", 32'(round_ctr), 32'd1);

        // asynchronous reset in the middle of WAIT
        do_start();
        wait_k(2);
        complete_display = 1'b1;
        tick();
        complete_display = 1'b0;
        wait_k(4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(obs_vec()), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(obs_vec()), 32'd0);
        do_start();
        chk("post_rst_round", 32'(round_ctr), 32'd0);
        chk("post_rst_pulse", 32'(rst_display), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start            = ($urandom % 8) == 0;
            complete_display = ($urandom % 4) == 0;
            complete_wait    = ($urandom % 6) == 0;
            complete_check   = ($urandom % 4) != 0;
            game_complete    = ($urandom % 8) == 0;
            round_ctr_out    = 4'($urandom % 16);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level sequencer for the memory game. It steps the display, wait (player input) and check blocks through a round.
- Each phase gets a one-cycle reset pulse, then a one-cycle enable pulse; the controller then waits for that phase's completion.
- It owns the 4-bit round counter, which it feeds to the check block and updates from the check block's result.
- It declares the game won or lost, and sits directly below the chip top alongside the phase blocks.

Parameters:
- WAIT_TIMEOUT, 1023: cycles allowed in WAIT after en_wait before the round is lost; 10-bit counter.
- CHECK_LAT, 2: cycles after the en_check pulse at which the check outputs are sampled; legal range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level; start/restart request
- rst_display  out  1  one-cycle reset pulse to display block
- en_display  out  1  one-cycle enable pulse to display block
- complete_display  in  1  display block finished
- rst_wait  out  1  one-cycle reset pulse to wait block
- en_wait  out  1  one-cycle enable pulse to wait block
- complete_wait  in  1  player sequence captured
- rst_check  out  1  one-cycle reset pulse to check block
- en_check  out  1  one-cycle enable pulse to check block
- complete_check  in  1  check passed
- game_complete  in  1  check passed on final round
- round_ctr_out  in  4  next round from check block
- round_ctr  out  4  current round, to display/check blocks
- phase  out  3  current state code
- win  out  1  high while in WIN
- lose  out  1  high while in LOSE

Behaviour:
- Reset (async, rst=1): state IDLE, round_ctr=0, all en_*=0, all rst_*=0, win=0, lose=0, timers cleared.
- State codes: IDLE=0, DISPLAY=1, WAIT=2, CHECK=3, WIN=4, LOSE=5. All outputs are registered.
- Phase entry: in the first cycle of DISPLAY, WAIT or CHECK, that phase's rst_* is 1. In the second cycle its en_* is 1. From the third cycle on, the controller watches the phase's completion input. No two pulses of different phases ever overlap.
- IDLE:
  - start=1 → DISPLAY, round_ctr cleared to 0.
- DISPLAY:
  - complete_display=1 (sampled from the third cycle on) → WAIT.
  - No timeout.
- WAIT:
  - complete_wait=1 → CHECK.
  - Timer counts cycles from the en_wait cycle. When the count reaches WAIT_TIMEOUT with no completion → LOSE.
  - Completion and timeout in the same cycle: completion wins.
- CHECK:
  - Sample point is exactly CHECK_LAT cycles after the en_check cycle.
  - complete_check=1 and game_complete=1 → WIN, round_ctr unchanged.
  - complete_check=1 and game_complete=0 → round_ctr := round_ctr_out, then DISPLAY.
  - complete_check=0 → LOSE, round_ctr unchanged.
  - Before the sample point, complete_check and game_complete are ignored.
- WIN / LOSE:
  - win or lose held at 1.
  - start=1 → DISPLAY with round_ctr cleared to 0; win and lose drop in the same cycle the state changes.
- Input scope:
  - start is ignored in DISPLAY, WAIT and CHECK.
  - Completion inputs are ignored outside their own phase.
- Round 15 safeguard: a pass with round_ctr=15 and game_complete=0 is treated as WIN, so the round counter never wraps.
- Reset mid-phase: immediate return to IDLE, all pulses drop asynchronously, and no partial pulse is issued after release.

Decomposition:
- Shared package game_pkg holds:
  - state encoding as a localparam set (IDLE..LOSE);
  - ROUND_W=4 and SEQ_W=32;
  - MAX_ROUND=15.
- One sub-module, phase_launcher. It produces the rst/en pulse pair from a one-cycle "launch" strobe and provides a "armed" flag for the completion watch. It is instantiated three times.
- The WAIT timeout counter and CHECK latency counter are inline.

Test Plan:
- Reset, start=1 for 1 cycle, complete_display at cycle 5, complete_wait at cycle 12, complete_check=1 with round_ctr_out=1 at the sample point → second DISPLAY entry; rst_display, en_display, rst_wait, en_wait, rst_check and en_check each pulse exactly once per phase; round_ctr=1.
- Same flow but complete_check=0 at the sample point → LOSE, lose=1, round_ctr stays 0. Then start=1 → DISPLAY, lose=0, round_ctr=0.
- Preload round 15 via passes with round_ctr_out 1..15, then a pass with game_complete=1 → WIN, win=1, round_ctr=15.
- WAIT with no complete_wait → LOSE exactly WAIT_TIMEOUT cycles after en_wait. Completion arriving in that same cycle → CHECK instead.
- Asserting complete_check one cycle early, then deasserting it at the sample point → LOSE. The early value is ignored.
- Assert rst during WAIT → phase=0 and all outputs 0 immediately (asynchronously). After release, start begins a fresh round 0.
